// File: rtl/pd_pluse_seq_ctrl.sv
// -----------------------------------------------------------------------------
// pd_pluse_seq_ctrl
//
// Sequence controller for the NMR pulse generator (pd_pluse_top). The host
// fills a small shadow table of pulse parameters while the controller is idle.
// On every acquisition start the table is downloaded into the generator one
// word at a time, then an echo train of echo_num pulses is fired. Completion
// of each pulse is tracked through the generator's en output, with a bounded
// wait for en to rise and a programmable idle gap between pulses.
//
// Parameters:
//   NLOAD    number of parameter words downloaded per sequence (1..6)
//   TMO_CYC  cycles allowed in WAIT_HI before declaring a timeout
//
// Ports:
//   clk_sys          system clock
//   rst_n            asynchronous active-low reset
//   cfg_we           host write strobe (accepted only while idle)
//   cfg_addr         host word address: 0..5 par, 6 echo_num, 7 gap
//   cfg_data         host write data
//   seq_start        start request, level sampled while idle
//   seq_abort        abort request, returns to idle on the next edge
//   pulse_en         en output of pd_pluse_top
//   pd_pluse_load    parameter load strobe
//   pd_pluse_choice  parameter index being loaded
//   pd_pluse_data    parameter value being loaded
//   pluse_start      one-cycle pulse trigger
//   seq_busy         high whenever the controller is not idle
//   seq_done         one-cycle completion pulse
//   echo_cnt         pulses completed in the current or last sequence
//   timeout_err      sticky flag, set when en never rose after a trigger
// -----------------------------------------------------------------------------
module pd_pluse_seq_ctrl #(
   parameter int NLOAD   = 6,
   parameter int TMO_CYC = 1000
) (
   input  logic        clk_sys,
   input  logic        rst_n,
   input  logic        cfg_we,
   input  logic [2:0]  cfg_addr,
   input  logic [15:0] cfg_data,
   input  logic        seq_start,
   input  logic        seq_abort,
   input  logic        pulse_en,
   output logic        pd_pluse_load,
   output logic [3:0]  pd_pluse_choice,
   output logic [15:0] pd_pluse_data,
   output logic        pluse_start,
   output logic        seq_busy,
   output logic        seq_done,
   output logic [15:0] echo_cnt,
   output logic        timeout_err
);

   localparam int TW = $clog2(TMO_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
   localparam logic [3:0]    LAST_IDX = 4'(NLOAD - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_SET,
      LOAD_STB,
      FIRE,
      WAIT_HI,
      WAIT_LO,
      GAP,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [5:0][15:0] par_q;
   logic [15:0]     echo_num_q;
   logic [15:0]     gap_q;
   logic [3:0]      idx_q, idx_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [15:0]     gap_cnt_q, gap_cnt_d;
   logic [15:0]     echo_cnt_d;
   logic [15:0]     echo_inc;
   logic            timeout_err_d;
   logic [3:0]      choice_d;
   logic [15:0]     data_d;

   // Table lookup by download index; indices beyond the table read as zero.
   function automatic logic [15:0] par_at(input logic [3:0] i);
      case (i)
         4'd0:    return par_q[0];
         4'd1:    return par_q[1];
         4'd2:    return par_q[2];
         4'd3:    return par_q[3];
         4'd4:    return par_q[4];
         4'd5:    return par_q[5];
         default: return 16'h0000;
      endcase
   endfunction

   // Host shadow table. Writes land only while the controller is idle so the
   // values being downloaded or used for the echo train never change mid-run.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         par_q      <= '0;
         echo_num_q <= 16'h0000;
         gap_q      <= 16'h0000;
      end else if (cfg_we && (state_q == IDLE)) begin
         case (cfg_addr)
            3'd0: par_q[0]   <= cfg_data;
            3'd1: par_q[1]   <= cfg_data;
            3'd2: par_q[2]   <= cfg_data;
            3'd3: par_q[3]   <= cfg_data;
            3'd4: par_q[4]   <= cfg_data;
            3'd5: par_q[5]   <= cfg_data;
            3'd6: echo_num_q <= cfg_data;
            3'd7: gap_q      <= cfg_data;
         endcase
      end
   end

   // Next-state and datapath decode. Every register defaults to holding its
   // value. Abort is checked before the state case so it overrides every
   // transition, including the DONE pulse, and leaves echo_cnt, timeout_err
   // and the choice/data outputs untouched. Choice and data are loaded on the
   // transition into LOAD_SET so they are already valid during LOAD_SET and
   // stay stable through the following LOAD_STB strobe.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      tmo_d         = tmo_q;
      gap_cnt_d     = gap_cnt_q;
      echo_cnt_d    = echo_cnt;
      timeout_err_d = timeout_err;
      choice_d      = pd_pluse_choice;
      data_d        = pd_pluse_data;
      echo_inc      = echo_cnt + 16'd1;

      if ((state_q != IDLE) && seq_abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (seq_start) begin
                  if (echo_num_q != 16'd0) begin
                     state_d       = LOAD_SET;
                     idx_d         = 4'd0;
                     echo_cnt_d    = 16'd0;
                     timeout_err_d = 1'b0;
                     choice_d      = 4'd0;
                     data_d        = par_at(4'd0);
                  end else begin
                     state_d = DONE;
                  end
               end
            end
            LOAD_SET: state_d = LOAD_STB;
            LOAD_STB: begin
               if (idx_q == LAST_IDX) begin
                  state_d = FIRE;
               end else begin
                  idx_d    = idx_q + 4'd1;
                  choice_d = idx_q + 4'd1;
                  data_d   = par_at(idx_q + 4'd1);
                  state_d  = LOAD_SET;
               end
            end
            FIRE: begin
               tmo_d   = '0;
               state_d = WAIT_HI;
            end
            WAIT_HI: begin
               if (pulse_en) begin
                  state_d = WAIT_LO;
               end else if (tmo_q == TMO_LAST) begin
                  timeout_err_d = 1'b1;
                  state_d       = DONE;
               end else begin
                  tmo_d = tmo_q + 1'b1;
               end
            end
            WAIT_LO: begin
               if (!pulse_en) begin
                  echo_cnt_d = echo_inc;
                  if (echo_inc == echo_num_q) begin
                     state_d = DONE;
                  end else if (gap_q == 16'd0) begin
                     state_d = FIRE;
                  end else begin
                     gap_cnt_d = gap_q - 16'd1;
                     state_d   = GAP;
                  end
               end
            end
            GAP: begin
               if (gap_cnt_q == 16'd0) begin
                  state_d = FIRE;
               end else begin
                  gap_cnt_d = gap_cnt_q - 16'd1;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers. The strobes are decoded from the next
   // state so every output comes straight from a flop yet lines up exactly
   // with the state it belongs to.
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         idx_q           <= 4'd0;
         tmo_q           <= '0;
         gap_cnt_q       <= 16'd0;
         echo_cnt        <= 16'd0;
         timeout_err     <= 1'b0;
         pd_pluse_choice <= 4'd0;
         pd_pluse_data   <= 16'd0;
         pd_pluse_load   <= 1'b0;
         pluse_start     <= 1'b0;
         seq_busy        <= 1'b0;
         seq_done        <= 1'b0;
      end else begin
         idx_q           <= idx_d;
         tmo_q           <= tmo_d;
         gap_cnt_q       <= gap_cnt_d;
         echo_cnt        <= echo_cnt_d;
         timeout_err     <= timeout_err_d;
         pd_pluse_choice <= choice_d;
         pd_pluse_data   <= data_d;
         pd_pluse_load   <= (state_d == LOAD_STB);
         pluse_start     <= (state_d == FIRE);
         seq_busy        <= (state_d != IDLE);
         seq_done        <= (state_d == DONE);
      end
   end

endmodule

// File: doc/pd_pluse_seq_ctrl.md
# pd_pluse_seq_ctrl

Sequence controller for the NMR pulse generator (`pd_pluse_top`).
- Holds a host-written shadow table of pulse parameters.
- On each acquisition start, downloads the table into the generator through its `pd_pluse_load`/`pd_pluse_choice`/`pd_pluse_data` port.
- Then fires an echo train of `echo_num` pulses via `pluse_start`, tracking each pulse's completion through the generator's `en` output.
- Sits between the host register bus and `pd_pluse_top`, in the `clk_sys` domain.

## Interface
Parameters:
- `NLOAD`, 6: number of parameter words downloaded per sequence (choice codes 0..NLOAD-1); legal range 1..6.
- `TMO_CYC`, 1000: maximum cycles from `pluse_start` to `en` rising before a timeout.

Ports:
- `clk_sys`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `cfg_we`  in  1  host write strobe, one cycle.
- `cfg_addr`  in  3  host word address.
- `cfg_data`  in  16  host write data.
- `seq_start`  in  1  start request, level sampled in IDLE.
- `seq_abort`  in  1  abort request, synchronous.
- `pulse_en`  in  1  `en` output of `pd_pluse_top`.
- `pd_pluse_load`  out  1  parameter load strobe.
- `pd_pluse_choice`  out  4  parameter index.
- `pd_pluse_data`  out  16  parameter value.
- `pluse_start`  out  1  pulse trigger, one cycle.
- `seq_busy`  out  1  high in every state except IDLE.
- `seq_done`  out  1  one-cycle completion pulse.
- `echo_cnt`  out  16  pulses completed in current or last sequence.
- `timeout_err`  out  1  sticky timeout flag.

## Operation
Register map (written only when `cfg_we` is high in IDLE; writes while busy are dropped):
- Addresses 0..5: `par[0..5]`.
- Address 6: `echo_num`.
- Address 7: `gap` (idle cycles between pulse end and next start).
- All table registers reset to 0.

State machine, states IDLE, LOAD_SET, LOAD_STB, FIRE, WAIT_HI, WAIT_LO, GAP, DONE:
- **IDLE**
  - `seq_start`=1 and `echo_num`≠0: go to LOAD_SET. Clear `idx`, `echo_cnt` and `timeout_err`.
  - `seq_start`=1 and `echo_num`=0: go to DONE with no load and no fire.
- **LOAD_SET**: drive `pd_pluse_choice`=`idx` and `pd_pluse_data`=`par[idx]`. Go to LOAD_STB.
- **LOAD_STB**: `pd_pluse_load`=1, with choice and data held. If `idx`=NLOAD-1, go to FIRE; otherwise increment `idx` and go to LOAD_SET.
- **FIRE**: `pluse_start`=1. Clear the timeout counter. Go to WAIT_HI.
- **WAIT_HI**
  - `pulse_en`=1: go to WAIT_LO.
  - Counter reaches TMO_CYC-1 with `pulse_en` still 0: set `timeout_err` and go to DONE.
- **WAIT_LO**
  - `pulse_en`=0: increment `echo_cnt`.
  - If the new count equals `echo_num`, go to DONE.
  - Otherwise, if `gap`=0 go to FIRE; if not, load the gap counter with `gap`-1 and go to GAP.
  - WAIT_LO has no timeout.
- **GAP**: count down; at 0 go to FIRE.
- **DONE**: `seq_done`=1. Go to IDLE.

Abort and output rules:
- `seq_abort`=1 in any non-IDLE state forces IDLE on the next edge.
  - No `seq_done` is issued.
  - `echo_cnt` holds its value; `timeout_err` is unchanged.
  - Abort takes priority over every other transition, including DONE.
- `pd_pluse_choice` and `pd_pluse_data` hold their last values outside the load states.
- `pd_pluse_load` and `pluse_start` are never high simultaneously.

## Timing
- All outputs come directly from flops.
- Reset values: all outputs 0; state IDLE.
- `seq_start` sampled at edge T gives:
  - LOAD_SET during T+1.
  - `pd_pluse_load` high during T+2, T+4, …, T+2·NLOAD.
  - `pluse_start` high during T+2·NLOAD+1 (T+13 for NLOAD=6).
- `pulse_en` high sampled at edge R gives WAIT_LO from R+1.
- `pulse_en` low sampled at edge E gives:
  - `echo_cnt` updated after E.
  - Next `pluse_start` high during cycle E+1+`gap`.
  - On the last echo, `seq_done` high during E+1.
- Timeout: `timeout_err` and DONE follow TMO_CYC cycles of WAIT_HI.
- `seq_start` held high through DONE restarts the sequence on the cycle after DONE.

## Test plan
1. Write `par[i]`=16'h1000+i, `echo_num`=3, `gap`=4; pulse `seq_start` at T; the generator model raises `en` 2 cycles after each `pluse_start` for 5 cycles.
   - Six loads at T+2..T+12 with choice 0..5 and data 1000..1005.
   - `pluse_start` at T+13 and twice more, each 5 cycles after `en` falls.
   - `echo_cnt`=3; one `seq_done`.
2. `echo_num`=0 with `seq_start`: no load, no `pluse_start`, `seq_done` at T+1.
3. `gap`=0, `echo_num`=2: second `pluse_start` on the cycle immediately after `en` falls is sampled low.
4. Generator model never raises `en`, TMO_CYC=1000:
   - `timeout_err`=1 and `seq_done` 1000 cycles after FIRE.
   - `echo_cnt`=0.
   - Next `seq_start` clears `timeout_err`.
5. `seq_abort` mid-load (after the third strobe) and again during GAP of echo 2:
   - Return to IDLE next cycle.
   - No further load or start, no `seq_done`.
   - `echo_cnt` held at 0 and 1 respectively.
6. Host write to address 6 while busy: ignored, and the sequence completes with the old `echo_num`. Assert `rst_n` low mid-WAIT_LO: all outputs 0 immediately.
